// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a valid/ready byte handshake.
// A byte is captured on the handshake edge. It is then sent as one start bit,
// eight data bits LSB first and one stop bit, each CLKS_PER_BIT clocks long.
// At least one IDLE cycle separates two frames.
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic        uart_clk,
    input  logic        rst_n,
    input  logic [7:0]  data_send,
    input  logic        data_valid,
    output logic        data_ready,
    output logic        tx,
    output logic        tx_done,
    output logic [15:0] frames_sent
);

    localparam int unsigned BaudW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BaudW-1:0] BaudLast = BaudW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [BaudW-1:0]  baud_q, baud_d;
    logic [2:0]        bit_idx_q, bit_idx_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic [15:0]       frames_q, frames_d;
    logic              bit_end;

    // Last clock of the current bit period.
    assign bit_end = (baud_q == BaudLast);

    // Next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        frames_d  = frames_q;

        case (state_q)
            StIdle: begin
                tx_d      = 1'b1;
                ready_d   = 1'b1;
                baud_d    = '0;
                bit_idx_d = 3'd0;
                // ready_q is a flop, so acceptance never loops back into data_ready.
                if (data_valid && ready_q) begin
                    shift_d = data_send;
                    state_d = StStart;
                    tx_d    = 1'b0;
                    ready_d = 1'b0;
                end
            end

            StStart: begin
                if (bit_end) begin
                    state_d   = StData;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = shift_q[0];
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            StData: begin
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = StStop;
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        // Present the next bit from the same edge that shifts it down.
                        tx_d      = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            StStop: begin
                if (bit_end) begin
                    state_d   = StIdle;
                    baud_d    = '0;
                    bit_idx_d = 3'd0;
                    tx_d      = 1'b1;
                    ready_d   = 1'b1;
                    done_d    = 1'b1;
                    frames_d  = frames_q + 16'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
                ready_d = 1'b1;
                baud_d  = '0;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'd0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            frames_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            frames_q  <= frames_d;
        end
    end

    // The line and every status output come straight from flops.
    assign tx          = tx_q;
    assign data_ready  = ready_q;
    assign tx_done     = done_q;
    assign frames_sent = frames_q;

`ifndef SYNTHESIS
    // data_ready mirrors the IDLE state exactly.
    ready_matches_idle: assert property (@(posedge uart_clk) disable iff (!rst_n)
        ready_q == (state_q == StIdle));

    // The done pulse is only ever seen once the machine is back in IDLE.
    done_only_in_idle: assert property (@(posedge uart_clk) disable iff (!rst_n)
        done_q |-> (state_q == StIdle));

    // An idle line is high.
    idle_line_high: assert property (@(posedge uart_clk) disable iff (!rst_n)
        (state_q == StIdle) |-> tx_q);
`endif

endmodule
